// File: rtl/motor_pwm_driver.sv
// Four-channel H-bridge PWM driver with per-motor soft-start ramp, dead time on reversal
// and a shared duty limit. All outputs are registered.
module motor_pwm_driver #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned RAMP_DIV    = 4,
  parameter int unsigned RAMP_STEP   = 16,
  parameter int unsigned DEAD_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          sel_protected,
  input  logic [PWM_BITS-1:0] duty_limit,
  output logic [7:0]          motor_out,
  output logic [3:0]          running
);

  localparam int unsigned PreW  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DeadW = $clog2(DEAD_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StRamp, StRun, StDead, StBrake} state_e;

  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [PreW-1:0]     presc_q;
  logic                ramp_tick;

  state_e              state_q [4];
  state_e              state_d [4];
  logic [PWM_BITS-1:0] duty_q  [4];
  logic [PWM_BITS-1:0] duty_d  [4];
  logic [DeadW-1:0]    dead_q  [4];
  logic [DeadW-1:0]    dead_d  [4];
  logic [3:0]          dir_q, dir_d;   // 0 forward, 1 reverse

  logic [7:0]          motor_out_d;
  logic [3:0]          running_d;
  logic [1:0]          cmd;
  logic [PWM_BITS:0]   sum;
  logic                pwm;

  assign ramp_tick = (presc_q == PreW'(RAMP_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      motor_out <= '0;
      running   <= '0;
      dir_q     <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= StIdle;
        duty_q[i]  <= '0;
        dead_q[i]  <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      presc_q   <= ramp_tick ? '0 : presc_q + PreW'(1);
      motor_out <= motor_out_d;
      running   <= running_d;
      dir_q     <= dir_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        duty_q[i]  <= duty_d[i];
        dead_q[i]  <= dead_d[i];
      end
    end
  end

  always_comb begin
    motor_out_d = '0;
    running_d   = '0;
    dir_d       = dir_q;
    cmd         = 2'b00;
    sum         = '0;
    pwm         = 1'b0;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      duty_d[i]  = duty_q[i];
      dead_d[i]  = dead_q[i];
      cmd        = sel_protected[2*i +: 2];
      // One bit wider than duty so the increment cannot wrap before the clamp.
      sum        = {1'b0, duty_q[i]} + (PWM_BITS + 1)'(RAMP_STEP);

      if (cmd == 2'b00) begin
        state_d[i] = StIdle;
        duty_d[i]  = '0;
      end else if (cmd == 2'b11) begin
        state_d[i] = StBrake;
        duty_d[i]  = '0;
      end else begin
        case (state_q[i])
          StIdle: begin
            dir_d[i]   = cmd[1];
            state_d[i] = StRamp;
          end
          StRamp, StRun: begin
            if (cmd[1] != dir_q[i]) begin
              state_d[i] = StDead;
              duty_d[i]  = '0;
              dead_d[i]  = DeadW'(DEAD_CYCLES);
            end else if (state_q[i] == StRun) begin
              if (duty_limit > duty_q[i]) state_d[i] = StRamp;
              else                        duty_d[i]  = duty_limit;
            end else if (duty_q[i] == duty_limit) begin
              state_d[i] = StRun;
            end else if (duty_q[i] > duty_limit) begin
              duty_d[i] = duty_limit;
            end else if (ramp_tick) begin
              duty_d[i] = (sum > {1'b0, duty_limit}) ? duty_limit : sum[PWM_BITS-1:0];
            end
          end
          StDead: begin
            // The direction is taken from the command present when dead time expires.
            if (dead_q[i] == '0) begin
              dir_d[i]   = cmd[1];
              state_d[i] = StRamp;
            end else begin
              dead_d[i] = dead_q[i] - DeadW'(1);
            end
          end
          StBrake: begin
            state_d[i] = StDead;
            duty_d[i]  = '0;
            dead_d[i]  = DeadW'(DEAD_CYCLES);
          end
          default: state_d[i] = StIdle;
        endcase
      end

      pwm = (pwm_cnt_q < duty_q[i]);
      case (state_q[i])
        StRamp, StRun: motor_out_d[2*i +: 2] = dir_q[i] ? {pwm, 1'b0} : {1'b0, pwm};
        StBrake:       motor_out_d[2*i +: 2] = 2'b11;
        default:       motor_out_d[2*i +: 2] = 2'b00;
      endcase
      running_d[i] = (state_q[i] == StRun);
    end
  end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Scoreboard bench for motor_pwm_driver: stimulus queues expected observations, a monitor
// records {running, motor_out} every cycle and checks queued items as they fall due.
module tb_motor_pwm_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sel_protected;
  logic [7:0] duty_limit;
  logic [7:0] motor_out;
  logic [3:0] running;

  motor_pwm_driver #(
    .PWM_BITS   (8),
    .RAMP_DIV   (4),
    .RAMP_STEP  (16),
    .DEAD_CYCLES(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sel_protected(sel_protected),
    .duty_limit   (duty_limit),
    .motor_out    (motor_out),
    .running      (running)
  );

  always #5 clk = ~clk;

  // kind 0: snapshot at cycle 'due'; kind 1: number of cycles in the 'len'-cycle window ending
  // at 'due' whose masked observation equals 'exp' must equal 'cnt'.
  typedef struct {
    string       name;
    int          kind;
    int          due;
    int          len;
    logic [11:0] mask;
    logic [11:0] exp;
    int          cnt;
  } item_t;

  item_t       sb[$];
  logic [11:0] hist [0:8191];
  int          cyc      = 0;
  int          checks   = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void snap(string n, int due, logic [11:0] mask, logic [11:0] exp);
    item_t it;
    it.name = n; it.kind = 0; it.due = due; it.len = 1;
    it.mask = mask; it.exp = exp; it.cnt = 0;
    sb.push_back(it);
  endfunction

  function automatic void count(string n, int due, int len, logic [11:0] mask,
                                logic [11:0] exp, int cnt);
    item_t it;
    it.name = n; it.kind = 1; it.due = due; it.len = len;
    it.mask = mask; it.exp = exp; it.cnt = cnt;
    sb.push_back(it);
  endfunction

  always @(negedge clk) begin
    hist[cyc % 8192] = {running, motor_out};
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].due <= cyc) begin
        item_t       it;
        logic [11:0] got;
        int          n;
        it = sb[k];
        checks++;
        if (it.kind == 0) begin
          got = hist[it.due % 8192] & it.mask;
          if (got != it.exp) begin
            failures++;
            $display("FAIL %s: got 0x%03h required 0x%03h (cycle %0d)", it.name, got, it.exp,
                     it.due);
          end
        end else begin
          n = 0;
          for (int j = it.due - it.len + 1; j <= it.due; j++)
            if ((hist[j % 8192] & it.mask) == it.exp) n++;
          if (n != it.cnt) begin
            failures++;
            $display("FAIL %s: got %0d matching cycles required %0d (window ending %0d)",
                     it.name, n, it.cnt, it.due);
          end
        end
        sb.delete(k);
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1; sel_protected = 8'h00; duty_limit = 8'd0;
    step(3);
    snap("reset_state", cyc, 12'hFFF, 12'h000);

    // Idle after release
    rst = 1'b0; c = cyc;
    count("idle_1000", c + 1000, 1000, 12'hFFF, 12'h000, 1000);
    step(1000);

    // Forward soft start to 128
    duty_limit = 8'd128; sel_protected = 8'h01; c = cyc;
    snap("ramp_not_yet_run", c + 20, 12'h100, 12'h000);
    snap("fwd_running", c + 45, 12'h100, 12'h100);
    count("in1_duty128", c + 305, 256, 12'h001, 12'h001, 128);
    count("in2_idle_fwd", c + 305, 300, 12'h002, 12'h002, 0);
    step(310);

    // Reversal through dead time
    sel_protected = 8'h02; c = cyc;
    snap("dead_not_running", c + 2, 12'h100, 12'h000);
    count("dead_9_cycles", c + 10, 9, 12'h003, 12'h000, 9);
    count("rev_in1_off", c + 320, 319, 12'h001, 12'h001, 0);
    count("rev_in2_duty128", c + 320, 256, 12'h002, 12'h002, 128);
    step(325);

    // All four running, then brake, brake->dead, stop
    sel_protected = 8'h56; c = cyc;
    snap("all_running", c + 50, 12'hF00, 12'hF00);
    step(60);
    sel_protected = 8'hFF; c = cyc;
    snap("brake_all", c + 2, 12'hFFF, 12'h0FF);
    step(5);
    sel_protected = 8'h55; c = cyc;
    count("brake_to_dead", c + 10, 9, 12'hFFF, 12'h000, 9);
    step(12);
    sel_protected = 8'h00; c = cyc;
    snap("stop_all", c + 2, 12'hFFF, 12'h000);
    count("stop_hold", c + 22, 20, 12'hFFF, 12'h000, 20);
    step(25);

    // Zero duty limit: RUN with no drive
    duty_limit = 8'd0; sel_protected = 8'h01; c = cyc;
    snap("lim0_running", c + 4, 12'h100, 12'h100);
    count("lim0_out_low", c + 100, 100, 12'h003, 12'h000, 100);
    step(100);
    sel_protected = 8'h00;
    step(4);

    // Limit drop clamps in RUN; limit rise resumes the ramp from the clamped value
    duty_limit = 8'd200; sel_protected = 8'h01;
    step(80);
    duty_limit = 8'd64; c = cyc;
    snap("clamp_running", c + 2, 12'h100, 12'h100);
    count("clamp_run_hold", c + 258, 258, 12'h100, 12'h100, 258);
    count("in1_duty64", c + 258, 256, 12'h001, 12'h001, 64);
    step(260);
    duty_limit = 8'd200; c = cyc;
    snap("raise_drops_run", c + 2, 12'h100, 12'h000);
    snap("ramp_from_64", c + 45, 12'h100, 12'h100);
    count("in1_duty200", c + 305, 256, 12'h001, 12'h001, 200);
    step(310);

    // Reset during ramp, then a fresh ramp from zero
    sel_protected = 8'h00;
    step(4);
    duty_limit = 8'd128; sel_protected = 8'h55;
    step(10);
    rst = 1'b1; c = cyc;
    snap("reset_mid_ramp", c + 1, 12'hFFF, 12'h000);
    step(3);
    rst = 1'b0; c = cyc;
    snap("restart_from_idle", c + 20, 12'hF00, 12'h000);
    snap("restart_running", c + 45, 12'hF00, 12'hF00);
    step(50);

    for (int k = 0; k < 400 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending items required 0", sb.size());
      failures += sb.size();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
